// File: rtl/audio_pkg.sv
// Shared constants and request-FSM encoding for the audio sample path.
package audio_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int FRAME_BITS = 32;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HAVE = 2'd2
   } req_state_t;

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock divider: bclk = clk/(2*BCLK_DIV), plus a strobe marking the
// clk cycle in which bclk is about to fall.
module bclk_gen #(
   parameter int BCLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic bclk,
   output logic fall
);

   localparam int DW = $clog2(BCLK_DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic          tc;

   assign tc   = (div_cnt == DIV_MAX);
   assign fall = bclk & tc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (tc) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_sample_tx.sv
// Requests one mono sample per frame and serialises it MSB-first on both
// channels of a left-justified stereo bus.
//
// state | meaning
// REQ   | issue a one-cycle generate_next, then wait
// WAIT  | request outstanding, capture sample_in on new_sample_ready
// HAVE  | fresh sample held, waiting for the next frame load
module i2s_sample_tx
   import audio_pkg::*;
#(
   parameter int BCLK_DIV = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                new_sample_ready,
   input  logic                underrun_clr,
   output logic                generate_next,
   output logic                bclk,
   output logic                lrclk,
   output logic                sdata,
   output logic                underrun
);

   logic                  fall;
   logic                  load;
   logic                  capture;
   logic [4:0]            bit_cnt;
   logic [FRAME_BITS-1:0] shift;
   logic [SAMPLE_W-1:0]   hold;
   logic [SAMPLE_W-1:0]   last;
   logic                  valid;
   logic                  gen_nxt;
   req_state_t            state;
   req_state_t            state_nxt;

   bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
      .clk   (clk),
      .reset (reset),
      .bclk  (bclk),
      .fall  (fall)
   );

   assign load    = fall && (bit_cnt == 5'd31);
   assign capture = (state == WAIT) && new_sample_ready;

   // Both are straight register taps, so lrclk and the new MSB move together.
   assign lrclk = bit_cnt[4];
   assign sdata = shift[FRAME_BITS-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt <= '0;
         shift   <= '0;
         last    <= '0;
      end else if (fall) begin
         bit_cnt <= bit_cnt + 5'd1;
         if (load) begin
            if (valid) begin
               shift <= {hold, hold};
               last  <= hold;
            end else begin
               shift <= {last, last};
            end
         end else begin
            shift <= shift << 1;
         end
      end
   end

   // A strobe landing on the load cycle is captured for the following frame;
   // the load itself still sees the old valid and replays.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold     <= '0;
         valid    <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (capture) begin
            hold  <= sample_in;
            valid <= 1'b1;
         end else if (load) begin
            valid <= 1'b0;
         end

         if (load && !valid) begin
            underrun <= 1'b1;
         end else if (underrun_clr) begin
            underrun <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= REQ;
         generate_next <= 1'b0;
      end else begin
         state         <= state_nxt;
         generate_next <= gen_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gen_nxt   = 1'b0;
      case (state)
         REQ: begin
            gen_nxt   = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (new_sample_ready) begin
               state_nxt = HAVE;
            end
         end
         HAVE: begin
            if (load) begin
               state_nxt = REQ;
            end
         end
         default: state_nxt = REQ;
      endcase
   end

endmodule
